imem_loader: RTL and testbench

- Writer-side counterpart to the instruction fetch path.
- Accepts 32-bit instruction words over a valid/ready stream and writes them into the byte-wide instruction memory, one byte per cycle, little-endian: byte k of a word goes to address base+4*i+k.
- Sits between the program source (host or UART front end) and the instruction memory write port; the CPU is held off while busy=1.

---
 rtl/imem_loader.sv | 178 +++++++++++++++++
 tb/tb_imem_loader.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory, little-endian, one byte per cycle.
// Optional running word checksum output enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned MEM_DEPTH   = 16,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic                   in_valid,
  input  logic [31:0]            in_data,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   error
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]            checksum
`endif
);

  // Wide enough that base + 4*count can never wrap.
  localparam int unsigned SUM_WIDTH = ADDR_WIDTH + COUNT_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_WORD = 3'd1,
    S_WRITE     = 3'd2,
    S_DONE      = 3'd3,
    S_ERR       = 3'd4
  } state_t;

  state_t                 state_q, state_nxt;
  logic [ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_nxt;
  logic [COUNT_WIDTH-1:0] words_left_q, words_left_nxt;
  logic [31:0]            word_q, word_nxt;
  logic [1:0]             idx_q, idx_nxt;

  logic                   in_ready_d;
  logic                   mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_d;
  logic [7:0]             mem_wdata_d;
  logic                   busy_d;
  logic                   done_d;
  logic                   error_d;

  logic [SUM_WIDTH-1:0]   end_addr_c;
  logic                   misaligned_c;
  logic                   out_of_range_c;
  logic                   reject_c;
  logic                   accept_c;

  // Request screening: word alignment and fit inside the memory.
  assign end_addr_c     = SUM_WIDTH'(base_addr) + (SUM_WIDTH'(word_count) << 2);
  assign misaligned_c   = |base_addr[1:0];
  assign out_of_range_c = end_addr_c > SUM_WIDTH'(MEM_DEPTH);
  assign reject_c       = misaligned_c | out_of_range_c;
  assign accept_c       = (state_q == S_WAIT_WORD) && in_valid;

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      words_left_q <= '0;
      word_q       <= '0;
      idx_q        <= '0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      cur_addr_q   <= cur_addr_nxt;
      words_left_q <= words_left_nxt;
      word_q       <= word_nxt;
      idx_q        <= idx_nxt;
      in_ready     <= in_ready_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
    end
  end

  // Next state and datapath updates.
  always_comb begin
    state_nxt      = state_q;
    cur_addr_nxt   = cur_addr_q;
    words_left_nxt = words_left_q;
    word_nxt       = word_q;
    idx_nxt        = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (reject_c) begin
            state_nxt = S_ERR;
          end else if (word_count == '0) begin
            state_nxt = S_DONE;
          end else begin
            cur_addr_nxt   = base_addr;
            words_left_nxt = word_count;
            state_nxt      = S_WAIT_WORD;
          end
        end
      end
      S_WAIT_WORD: begin
        if (accept_c) begin
          word_nxt  = in_data;
          idx_nxt   = 2'd0;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_nxt = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          cur_addr_nxt   = cur_addr_q + ADDR_WIDTH'(4);
          words_left_nxt = words_left_q - COUNT_WIDTH'(1);
          state_nxt      = (words_left_q == COUNT_WIDTH'(1)) ? S_DONE : S_WAIT_WORD;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output values decoded from the upcoming state so the registers line up with it.
  always_comb begin
    in_ready_d  = (state_nxt == S_WAIT_WORD);
    mem_we_d    = (state_nxt == S_WRITE);
    busy_d      = (state_nxt != S_IDLE);
    done_d      = (state_nxt == S_DONE);
    error_d     = (state_nxt == S_ERR);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (mem_we_d) begin
      mem_addr_d = cur_addr_nxt + ADDR_WIDTH'(idx_nxt);
      case (idx_nxt)
        2'd0:    mem_wdata_d = word_nxt[7:0];
        2'd1:    mem_wdata_d = word_nxt[15:8];
        2'd2:    mem_wdata_d = word_nxt[23:16];
        default: mem_wdata_d = word_nxt[31:24];
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic        start_ok_c;
  logic [31:0] checksum_q;

  assign start_ok_c = (state_q == S_IDLE) && start && !reject_c;
  assign checksum   = checksum_q;

  // Modulo-2^32 sum of accepted words, restarted by every accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (start_ok_c) begin
      checksum_q <= '0;
    end else if (accept_c) begin
      checksum_q <= checksum_q + in_data;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a byte-level reference model feeds expected writes and events
// into queues that an independent monitor drains. Checks the checksum when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  localparam int unsigned AW    = 32;
  localparam int unsigned CW    = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] word_count;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          busy;
  logic          done;
  logic          error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  always #5 clk = ~clk;

  imem_loader #(.MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  typedef struct {
    bit          is_done;
    bit          after_we;
    logic [31:0] csum;
  } evt_t;

  int          checks   = 0;
  int          failures = 0;
  wr_t         exp_wr[$];
  evt_t        exp_evt[$];
  logic [31:0] words[$];
  bit          prev_we = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endfunction

  // Reference model: screens the request and lists every byte write plus the closing event.
  function automatic bit model_start(input logic [AW-1:0] base, input int cnt);
    longint unsigned last;
    logic [31:0]     sum;
    logic [31:0]     w;
    wr_t             wr;
    evt_t            e;
    last = longint'(base) + longint'(4 * cnt);
    sum  = 32'd0;
    if (base[1:0] != 2'd0 || last > longint'(DEPTH)) begin
      words.delete();
      e.is_done = 1'b0; e.after_we = 1'b0; e.csum = 32'd0;
      exp_evt.push_back(e);
      return 1'b0;
    end
    for (int i = 0; i < cnt; i++) begin
      w   = words[i];
      sum = sum + w;
      for (int k = 0; k < 4; k++) begin
        wr.addr = base + AW'(4 * i + k);
        wr.data = w[8*k +: 8];
        exp_wr.push_back(wr);
      end
    end
    e.is_done = 1'b1; e.after_we = (cnt > 0); e.csum = sum;
    exp_evt.push_back(e);
    return 1'b1;
  endfunction

  // Monitor: every write and every done/error pulse is matched against the queues.
  always @(negedge clk) begin
    wr_t  w;
    evt_t e;
    if (!reset) begin
      if (mem_we) begin
        chk("ready_during_write", in_ready, 0);
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write actual addr=0x%0h data=0x%0h required no write", mem_addr, mem_wdata);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", mem_addr, w.addr);
          chk("wr_data", mem_wdata, w.data);
        end
      end
      if (done || error) begin
        chk("busy_at_evt", busy, 1);
        if (exp_evt.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_event actual done=%0b error=%0b required none", done, error);
        end else begin
          e = exp_evt.pop_front();
          chk("evt_kind", {done, error}, e.is_done ? 2'b10 : 2'b01);
          if (e.is_done) begin
            chk("done_after_write", prev_we, e.after_we);
            chk("writes_left_at_done", exp_wr.size(), 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk("checksum", checksum, e.csum);
`endif
          end
        end
      end
    end
    prev_we = mem_we;
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  task automatic pulse_start(input logic [AW-1:0] base, input int cnt);
    start      = 1'b1;
    base_addr  = base;
    word_count = CW'(cnt);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic start_load(input logic [AW-1:0] base, input int cnt);
`ifdef IMEM_LOADER_CHECKSUM_EN
    bit acc;
    acc = model_start(base, cnt);
    pulse_start(base, cnt);
    if (acc) chk("checksum_cleared", checksum, 0);
`else
    void'(model_start(base, cnt));
    pulse_start(base, cnt);
`endif
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    int n;
    int gap;
    gap = $urandom_range(0, gap_max);
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("handshake", in_ready, 1);
    if (in_ready) @(negedge clk);
  endtask

  task automatic send_all(input int gap_max);
    foreach (words[i]) send_word(words[i], gap_max);
    in_valid = 1'b0;
  endtask

  task automatic fill_words(input int cnt);
    words.delete();
    for (int i = 0; i < cnt; i++) words.push_back($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_evt.size() != 0 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    chk("evt_drain", exp_evt.size(), 0);
    chk("wr_drain", exp_wr.size(), 0);
    exp_evt.delete();
    exp_wr.delete();
    @(negedge clk); #1;
    chk("busy_after", busy, 0);
    chk("pulse_after", done | error, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [AW-1:0] b;
    int c;
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic two-word load, second word held valid through WRITE.
    words.delete();
    words.push_back(32'h0050_0093);
    words.push_back(32'h00A0_0113);
    start_load(32'd0, 2);
    send_all(0);
    wait_idle();

    // Long stall in WAIT_WORD.
    fill_words(1);
    start_load(32'd4, 1);
    repeat (10) begin
      chk("stall_ready", in_ready, 1);
      chk("stall_busy", busy, 1);
      @(negedge clk);
    end
    send_all(0);
    wait_idle();

    // Rejections and the top-of-memory boundary.
    fill_words(1);
    start_load(32'd2, 1);
    wait_idle();
    fill_words(3);
    start_load(32'd8, 3);
    wait_idle();
    fill_words(1);
    start_load(32'd12, 1);
    send_all(1);
    wait_idle();

    // Zero-length load.
    words.delete();
    start_load(32'd0, 0);
    wait_idle();

    // start while busy is ignored.
    fill_words(2);
    start_load(32'd0, 2);
    send_word(words[0], 0);
    pulse_start(32'd2, 1);
    send_word(words[1], 1);
    in_valid = 1'b0;
    wait_idle();

    // Checksum wraps modulo 2^32.
    words.delete();
    words.push_back(32'hFFFF_FFFF);
    words.push_back(32'h0000_0002);
    start_load(32'd0, 2);
    send_all(2);
    wait_idle();

    // Reset during the second byte of the first word.
    fill_words(2);
    start_load(32'd0, 2);
    send_word(words[0], 0);
    n = 0;
    #1;
    while (!(mem_we && mem_addr == 32'd1) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reached_byte1", mem_addr, 1);
    reset    = 1'b1;
    in_valid = 1'b0;
    chk("pending_at_reset", exp_wr.size(), 6);
    exp_wr.delete();
    exp_evt.delete();
    @(negedge clk); #1;
    check_outputs_zero("midreset");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    fill_words(2);
    start_load(32'd8, 2);
    send_all(1);
    wait_idle();

    // Randomized loads, including misaligned and oversized requests.
    repeat (30) begin
      n = $urandom_range(0, 9);
      b = (n < 8) ? AW'(4 * $urandom_range(0, 4)) : AW'($urandom_range(0, 24));
      c = $urandom_range(0, 5);
      fill_words(c);
      start_load(b, c);
      send_all(3);
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
